// File: rtl/seven_seg_mux_n.sv
// Multiplexed DIGITS-digit common-anode seven-segment driver with a sequential
// double-dabble binary-to-BCD converter. Define SEVEN_SEG_LZB_EN to build leading-zero blanking.
module seven_seg_mux_n #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  input  logic              err,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned REF_W = $clog2(REFRESH_DIV);
  localparam int unsigned SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic              pend_q, pend_d;
  logic [WIDTH-1:0]  pend_val_q, pend_val_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic [REF_W-1:0]  ref_q, ref_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic [SR_W-1:0]   sr_adj;
  logic [SR_W-1:0]   sr_shift;
  logic              shift_out;
  logic [3:0]        nib;
  logic              dp_bit;
  logic [DIGITS-1:0] sel_oh;
  logic              blank;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0000001;
      4'd1:    glyph = 7'b1001111;
      4'd2:    glyph = 7'b0010010;
      4'd3:    glyph = 7'b0000110;
      4'd4:    glyph = 7'b1001100;
      4'd5:    glyph = 7'b0100100;
      4'd6:    glyph = 7'b0100000;
      4'd7:    glyph = 7'b0001111;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0000100;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step: add-3 correction on every BCD nibble, then shift left.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_q[WIDTH + 4*i +: 4] >= 4'd5) begin
        sr_adj[WIDTH + 4*i +: 4] = sr_q[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
    shift_out = sr_adj[SR_W-1];
    sr_shift  = {sr_adj[SR_W-2:0], 1'b0};
  end

  // Converter FSM with a single-entry pending request buffer.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_acc_d  = ovf_acc_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d   = S_SHIFT;
          sr_d      = {BCD_W'(0), value};
          cnt_d     = '0;
          ovf_acc_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_SHIFT: begin
        sr_d      = sr_shift;
        cnt_d     = cnt_q + CNT_W'(1);
        ovf_acc_d = ovf_acc_q | shift_out;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          disp_d     = sr_shift[SR_W-1 -: BCD_W];
          overflow_d = ovf_acc_q | shift_out;
          if (load || pend_q) begin
            // A load on the completion edge is newer than any pending value.
            sr_d      = {BCD_W'(0), (load ? value : pend_val_q)};
            cnt_d     = '0;
            ovf_acc_d = 1'b0;
            pend_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else if (load) begin
          pend_d     = 1'b1;
          pend_val_d = value;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Refresh timer and digit scan.
  always_comb begin
    ref_d = ref_q + REF_W'(1);
    sel_d = sel_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      sel_d = (sel_q == SEL_W'(DIGITS - 1)) ? '0 : sel_q + SEL_W'(1);
    end
  end

  assign sel_oh = DIGITS'(1) << sel_q;

  always_comb begin
    nib    = 4'd0;
    dp_bit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sel_q == SEL_W'(i)) begin
        nib    = disp_q[4*i +: 4];
        dp_bit = dp_mask[i];
      end
    end
  end

`ifdef SEVEN_SEG_LZB_EN
  logic [DIGITS-1:0] lz;

  // lz[i]: digit i and every digit above it are zero.
  always_comb begin
    lz           = '0;
    lz[DIGITS-1] = (disp_q[BCD_W-1 -: 4] == 4'd0);
    for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp_q[4*i +: 4] == 4'd0);
    end
  end

  assign blank = blank_lz && !err && !overflow_q && (sel_q != '0) && |(lz & sel_oh);
`else
  logic unused_blank_lz;
  assign unused_blank_lz = blank_lz;
  assign blank           = 1'b0;
`endif

  always_comb begin
    seg_d = glyph(nib);
    if (err) begin
      seg_d = 7'b0110000;
    end else if (overflow_q) begin
      seg_d = 7'b1111110;
    end else if (blank) begin
      seg_d = 7'b1111111;
    end
    dp_d = blank | ~dp_bit;
    an_d = ~sel_oh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_acc_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      ref_q      <= '0;
      sel_q      <= '0;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
      an_q       <= '1;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_acc_q  <= ovf_acc_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      ref_q      <= ref_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// Self-checking bench for seven_seg_mux_n: vector table, random loads against a decimal model,
// and hand sequences for back-to-back loads, err display and mid-conversion reset.
module tb_seven_seg_mux_n;

  localparam int unsigned D  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned RD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] value = '0;
  logic         load = 1'b0;
  logic         err = 1'b0;
  logic         blank_lz = 1'b0;
  logic [D-1:0] dp_mask = '0;
  logic [6:0]   seg;
  logic         dp;
  logic [D-1:0] an;
  logic         busy;
  logic         overflow;

  seven_seg_mux_n #(.DIGITS(D), .WIDTH(W), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .err(err), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .seg(seg), .dp(dp), .an(an), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the scan position follows directly from this count.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int checks = 0;
  int failures = 0;

  int           mval = 0;
  bit           merr = 1'b0;
  bit           mblank = 1'b0;
  logic [D-1:0] mmask = '0;
  bit           lzb_built;
  int           lim;
  logic [6:0]   glyph_t [10];

  typedef struct {
    int         v;
    bit         bl;
    logic [3:0] mask;
    bit         ovf;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dig(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  // Expected {seg, dp} for digit i from the decimal value and the display rules.
  function automatic logic [7:0] exp_out(input int i);
    bit ovf;
    int msd;
    bit blanked;
    logic [6:0] s;
    logic d;
    ovf = (mval >= lim);
    msd = 0;
    for (int k = 0; k < int'(D); k++) if (dig(mval, k) != 0) msd = k;
    blanked = lzb_built && mblank && !merr && !ovf && (i > msd);
    if (merr)         s = 7'b0110000;
    else if (ovf)     s = 7'b1111110;
    else if (blanked) s = 7'b1111111;
    else              s = glyph_t[dig(mval, i)];
    d = blanked ? 1'b1 : ~mmask[i];
    return {s, d};
  endfunction

  task automatic do_load(input int v);
    int n;
    @(negedge clk);
    value = W'(v);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("busy_cycles v=%0d", v), n, W);
    mval = v;
  endtask

  // Watch one full frame and compare every sampled cycle against the model.
  task automatic check_display(input string tag);
    logic [7:0]   e;
    logic [D-1:0] ean;
    int           d;
    repeat (2) @(negedge clk);
    check({tag, " overflow"}, overflow, (mval >= lim));
    for (int c = 0; c < int'(D * RD); c++) begin
      @(negedge clk);
      d   = ((cyc - 1) / int'(RD)) % int'(D);
      e   = exp_out(d);
      ean = ~(D'(1) << d);
      check($sformatf("%s an", tag), an, ean);
      check($sformatf("%s seg d%0d", tag, d), seg, e[7:1]);
      check($sformatf("%s dp d%0d", tag, d), dp, e[0]);
    end
  endtask

  initial begin
    bit saw22;
    int n;
    int v;
    glyph_t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
`ifdef SEVEN_SEG_LZB_EN
    lzb_built = 1'b1;
`else
    lzb_built = 1'b0;
`endif
    lim = 1;
    for (int k = 0; k < int'(D); k++) lim = lim * 10;

    tbl[0] = '{1234,  1'b0, 4'b0000, 1'b0};
    tbl[1] = '{10000, 1'b0, 4'b0001, 1'b1};
    tbl[2] = '{9999,  1'b0, 4'b0000, 1'b0};
    tbl[3] = '{42,    1'b1, 4'b0100, 1'b0};
    tbl[4] = '{0,     1'b1, 4'b0000, 1'b0};
    tbl[5] = '{65535, 1'b0, 4'b1111, 1'b1};
    tbl[6] = '{1000,  1'b1, 4'b1000, 1'b0};
    tbl[7] = '{305,   1'b1, 4'b0011, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst seg", seg, 7'b1111111);
    check("rst dp", dp, 1'b1);
    check("rst an", an, 4'b1111);
    check("rst busy", busy, 1'b0);
    check("rst overflow", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("first an", an, 4'b1110);
    check("first seg", seg, 7'b0000001);
    check_display("idle_zero");

    // Table-driven loads
    for (int i = 0; i < 8; i++) begin
      blank_lz = tbl[i].bl;
      dp_mask  = tbl[i].mask;
      mblank   = tbl[i].bl;
      mmask    = tbl[i].mask;
      do_load(tbl[i].v);
      check($sformatf("tbl%0d ovf", i), overflow, tbl[i].ovf);
      check_display($sformatf("tbl%0d", i));
    end

    // Random loads
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 9999));
      mblank   = 1'($urandom_range(0, 1));
      mmask    = D'($urandom_range(0, 15));
      blank_lz = mblank;
      dp_mask  = mmask;
      do_load(v);
      check_display($sformatf("rnd%0d", i));
    end

    // Back-to-back loads: 11 runs, 22 is superseded by 33 while pending
    blank_lz = 1'b0; mblank = 1'b0;
    dp_mask  = '0;   mmask  = '0;
    do_load(0);
    saw22 = 1'b0;
    @(negedge clk); value = W'(11); load = 1'b1;
    @(negedge clk); n = (busy === 1'b1) ? 1 : 0; value = W'(22);
    @(negedge clk); if (busy === 1'b1) n++; value = W'(33);
    @(negedge clk); if (busy === 1'b1) n++; load = 1'b0;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (an !== 4'b1111 && seg === glyph_t[2]) saw22 = 1'b1;
      if (busy !== 1'b1) break;
      n++;
    end
    check("b2b busy_cycles", n, 2 * W);
    mval = 33;
    for (int g = 0; g < int'(D * RD); g++) begin
      @(negedge clk);
      if (an !== 4'b1111 && seg === glyph_t[2]) saw22 = 1'b1;
    end
    check("b2b 22_shown", saw22, 1'b0);
    check_display("b2b");

    // Error display with dp on digit 1 only
    err = 1'b1; merr = 1'b1;
    dp_mask = 4'b0010; mmask = 4'b0010;
    check_display("err");
    err = 1'b0; merr = 1'b0;
    dp_mask = '0; mmask = '0;

    // Reset in the middle of a conversion
    do_load(65535);
    check("pre_rst overflow", overflow, 1'b1);
    @(negedge clk); value = W'(1234); load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst seg", seg, 7'b1111111);
    check("midrst dp", dp, 1'b1);
    check("midrst an", an, 4'b1111);
    check("midrst busy", busy, 1'b0);
    check("midrst overflow", overflow, 1'b0);
    @(negedge clk);
    rst  = 1'b0;
    mval = 0;
    @(negedge clk);
    check("postrst an", an, 4'b1110);
    check("postrst busy", busy, 1'b0);
    check_display("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
